// File: rtl/ecc_pkg.sv
// Shared field types and constants for the secp256k1 modular-arithmetic primitives.
package ecc_pkg;

    localparam int FIELD_W = 256;

    typedef logic [FIELD_W-1:0] field_t;

    localparam field_t SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

endpackage

// File: rtl/mod_add_sub.sv
// Combinational modular add (op=0) / subtract (op=1) for operands already in [0, P-1].
module mod_add_sub
    import ecc_pkg::*;
#(
    parameter int                WIDTH = FIELD_W,
    parameter logic [WIDTH-1:0]  P     = SECP256K1_P
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] sum_red;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        sum_red = sum - {1'b0, P};
        if (op) begin
            // A set borrow bit means a < b; adding P wraps back into range.
            y = diff[WIDTH] ? (diff[WIDTH-1:0] + P) : diff[WIDTH-1:0];
        end else begin
            y = (sum >= {1'b0, P}) ? sum_red[WIDTH-1:0] : sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mod_half.sv
// Combinational modular halving: (x + (x odd ? P : 0)) / 2, exact for odd P.
module mod_half
    import ecc_pkg::*;
#(
    parameter int                WIDTH = FIELD_W,
    parameter logic [WIDTH-1:0]  P     = SECP256K1_P
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, x} + (x[0] ? {1'b0, P} : {(WIDTH+1){1'b0}});
        y   = sum[WIDTH:1];
    end

endmodule

// File: rtl/mod_inverse.sv
// Sequential modular inverse a^-1 mod P via binary extended Euclid, one step per clock.
module mod_inverse
    import ecc_pkg::*;
#(
    parameter int                WIDTH      = FIELD_W,
    parameter logic [WIDTH-1:0]  P          = SECP256K1_P,
    parameter int                MAX_CYCLES = 1100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] inv
);

    localparam int             CNT_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] a_red;
    logic [WIDTH-1:0] x1_half, x2_half;
    logic [WIDTH-1:0] x1_sub, x2_sub;

    mod_half #(.WIDTH(WIDTH), .P(P)) u_half_x1 (.x(x1_q), .y(x1_half));
    mod_half #(.WIDTH(WIDTH), .P(P)) u_half_x2 (.x(x2_q), .y(x2_half));

    mod_add_sub #(.WIDTH(WIDTH), .P(P)) u_sub_x1 (
        .a(x1_q), .b(x2_q), .op(1'b1), .y(x1_sub)
    );
    mod_add_sub #(.WIDTH(WIDTH), .P(P)) u_sub_x2 (
        .a(x2_q), .b(x1_q), .op(1'b1), .y(x2_sub)
    );

    // 2^WIDTH < 2P, so one conditional subtract fully reduces the operand.
    always_comb begin
        a_red = (a_q >= P) ? (a_q - P) : a_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle still belongs to the finished operation.
                if (start && !done_q) begin
                    a_d     = a;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                if (a_red == '0) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    inv_d   = '0;
                    state_d = IDLE;
                end else begin
                    u_d     = a_red;
                    v_d     = P;
                    x1_d    = WIDTH'(1);
                    x2_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (u_q == WIDTH'(1)) begin
                    inv_d   = x1_q;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else if (v_q == WIDTH'(1)) begin
                    inv_d   = x2_q;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    inv_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = x1_sub;
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = x2_sub;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            cnt_q   <= '0;
            inv_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == LOAD) || (state_q == RUN);
    assign done = done_q;
    assign err  = err_q;
    assign inv  = inv_q;

endmodule

// File: tb/tb_mod_inverse.sv
// Scoreboard bench for mod_inverse: stimulus pushes expectations, a monitor pops on done.
module tb_mod_inverse;
    import ecc_pkg::*;

    localparam int     MAXC = 1100;
    localparam field_t P    = SECP256K1_P;
    localparam field_t INV2 =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;
    localparam field_t INV3 =
        256'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAA9_FFFFFD75;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   start = 1'b0;
    field_t a = '0;
    logic   busy, done, err;
    field_t inv;

    mod_inverse #(.WIDTH(256), .P(P), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a),
        .busy(busy), .done(done), .err(err), .inv(inv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic   err;
        field_t inv;
        field_t a;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    field_t last_inv = '0;
    logic   last_err = 1'b0;

    function automatic field_t mulmod(field_t x, field_t y);
        logic [511:0] t;
        logic [511:0] m;
        t = {256'b0, x} * {256'b0, y};
        m = t % {256'b0, P};
        return m[255:0];
    endfunction

    // Independent reference: Fermat inverse x^(P-2) mod P.
    function automatic field_t ref_inv(field_t x);
        field_t xr, r, e;
        xr = x % P;
        r  = 256'd1;
        e  = P - 256'd2;
        for (int i = 255; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i]) r = mulmod(r, xr);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int bound);
        checks++;
        if (act > bound) begin
            errors++;
            $display("FAIL %s: got %0d required <= %0d", name, act, bound);
        end
    endtask

    // Monitor: compares every done against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 inv=%h required no done", inv);
                end else begin
                    e = sb_q.pop_front();
                    check("err", {255'b0, err}, {255'b0, e.err});
                    check("inv", inv, e.inv);
                    if (!e.err) check("a_times_inv", mulmod(e.a % P, inv), 256'd1);
                end
                last_inv = inv;
                last_err = err;
            end else if (inv !== last_inv || err !== last_err) begin
                checks++;
                errors++;
                $display("FAIL hold: got inv=%h err=%0b required inv=%h err=%0b",
                         inv, err, last_inv, last_err);
            end
        end
    end

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Issue one start; optionally pulse start (with a garbage operand) while busy.
    task automatic run_op(input field_t av, input logic exp_err, input field_t exp_inv,
                          input bit pulse_busy, output int lat);
        exp_t e;
        int   cyc;
        bit   got;
        @(negedge clk);
        e.err = exp_err;
        e.inv = exp_inv;
        e.a   = av;
        sb_q.push_back(e);
        a     = av;
        start = 1'b1;
        cyc   = 0;
        got   = 0;
        while (!got && cyc < MAXC + 6) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1;
            end else begin
                start = pulse_busy && (cyc % 2 == 1);
                a     = ~av;
            end
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles required done", cyc);
            finish_run();
        end
        lat = cyc - 1;
    endtask

    initial begin
        int     lat;
        field_t x;

        #1;
        check("reset_busy", {255'b0, busy}, 256'd0);
        check("reset_done", {255'b0, done}, 256'd0);
        check("reset_err",  {255'b0, err},  256'd0);
        check("reset_inv",  inv, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(256'd1, 1'b0, 256'd1, 0, lat);
        check("lat_a1", lat, 2);

        run_op(256'd2, 1'b0, INV2, 0, lat);
        check_le("lat_a2", lat, 1 + MAXC);

        run_op(256'd0, 1'b1, 256'd0, 0, lat);
        check_le("lat_a0", lat, 2);

        run_op(P, 1'b1, 256'd0, 0, lat);
        check_le("lat_aP", lat, 2);

        // Back-to-back: a=1 accepted the cycle after the previous done.
        run_op(256'd1, 1'b0, 256'd1, 0, lat);
        check("lat_a1_b2b", lat, 2);

        run_op(P - 256'd1, 1'b0, P - 256'd1, 1, lat);
        check_le("lat_pm1", lat, 1 + MAXC);

        // Start coincident with done must be ignored.
        a     = 256'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", {255'b0, busy}, 256'd0);
        repeat (4) @(negedge clk);

        run_op(256'd3, 1'b0, INV3, 1, lat);
        run_op(P + 256'd3, 1'b0, INV3, 0, lat);
        check_le("lat_p3", lat, 1 + MAXC);

        x = {1'b1, 255'b0};
        run_op(x, 1'b0, ref_inv(x), 1, lat);
        x = '1;
        run_op(x, 1'b0, ref_inv(x), 0, lat);

        for (int i = 0; i < 8; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
            x = x % P;
            if (x == '0) x = 256'd1;
            run_op(x, 1'b0, ref_inv(x), 1, lat);
            check_le("lat_rand", lat, 1 + MAXC);
        end

        // Reset in the middle of a=5.
        @(negedge clk);
        a     = 256'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        check("busy_before_reset", {255'b0, busy}, 256'd1);
        rst_n    = 1'b0;
        last_inv = '0;
        last_err = 1'b0;
        #1;
        check("rst_busy", {255'b0, busy}, 256'd0);
        check("rst_done", {255'b0, done}, 256'd0);
        check("rst_inv",  inv, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", {255'b0, busy}, 256'd0);

        run_op(256'd5, 1'b0, ref_inv(256'd5), 0, lat);
        check_le("lat_a5", lat, 1 + MAXC);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        finish_run();
    end

endmodule
